// File: rtl/serial_frame_pkg.sv
// Purpose: shared FSM state encodings and default sizing for serial_frame_tx.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_frame_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH        = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 4;

endpackage

// File: rtl/serial_frame_tx_bit_timer.sv
// Purpose: bit-period counter; tick marks the last cycle of each bit period.
// Latency: tick is combinational from the counter; counter restarts at 0 when enabled.
// Backpressure: none; counts freely whenever enable is high.
// Ports: clock, reset (sync, active-high), enable (count while high), tick (final cycle of period).
module bit_timer
    import serial_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // Held at zero while disabled so every frame starts on a fresh bit period.
    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            cnt <= '0;
        end else if (cnt == LAST_CNT) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = enable && (cnt == LAST_CNT);

endmodule

// File: rtl/serial_frame_tx.sv
// Purpose: parallel-to-serial frame transmitter (start bit 0, WIDTH data bits LSB first, stop bit 1).
// Latency: serial_out shows the start bit the cycle after the load handshake; frame is (WIDTH+2)*CLKS_PER_BIT cycles.
// Backpressure: load_ready only in IDLE (including the done cycle); load_valid is ignored otherwise.
// Ports: clock, reset (sync, active-high), data_in/load_valid/load_ready (payload handshake),
//        serial_out (registered line, idles high), busy (frame in progress), done (1-cycle completion pulse).
module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    localparam int               IDX_W    = $clog2(WIDTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic [IDX_W-1:0] bit_idx;
    logic [IDX_W-1:0] bit_idx_nxt;
    logic             serial_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             ready_en;
    logic             handshake;
    logic             timer_en;
    logic             tick;

    // ready_en is a registered "out of reset" flag so load_ready stays low on
    // the reset edge and rises on the first edge after reset is released,
    // without a combinational path from the reset input.
    assign load_ready = (state == IDLE) && ready_en;
    assign handshake  = load_valid && load_ready;
    assign timer_en   = (state != IDLE);

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clock (clock),
        .reset (reset),
        .enable(timer_en),
        .tick  (tick)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (handshake) next_state = START;
            START:   if (tick) next_state = DATA;
            DATA:    if (tick && (bit_idx == LAST_IDX)) next_state = STOP;
            STOP:    if (tick) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Payload shifter and bit index: load on handshake, advance one bit per DATA period.
    always_comb begin
        shreg_nxt   = shreg;
        bit_idx_nxt = bit_idx;
        if (handshake) begin
            shreg_nxt   = data_in;
            bit_idx_nxt = '0;
        end else if ((state == DATA) && tick) begin
            shreg_nxt   = shreg >> 1;
            bit_idx_nxt = (bit_idx == LAST_IDX) ? '0 : bit_idx + 1'b1;
        end
    end

    // Output logic: computed from the upcoming state so the registered outputs
    // line up with the state they describe.
    always_comb begin
        serial_nxt = 1'b1;
        busy_nxt   = (next_state != IDLE);
        done_nxt   = (state == STOP) && (next_state == IDLE);
        case (next_state)
            START:   serial_nxt = 1'b0;
            DATA:    serial_nxt = shreg_nxt[0];
            default: serial_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            serial_out <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            ready_en   <= 1'b0;
            shreg      <= '0;
            bit_idx    <= '0;
        end else begin
            serial_out <= serial_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            ready_en   <= 1'b1;
            shreg      <= shreg_nxt;
            bit_idx    <= bit_idx_nxt;
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Purpose: self-checking bench for serial_frame_tx (default 8-bit/4-clock instance and a 4-bit/1-clock instance).
// Latency: inputs change and outputs are sampled on the falling clock edge.
// Backpressure: expected line bits are queued at load time and popped by a monitor while busy.
module tb_serial_frame_tx;
    import serial_frame_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [7:0] data_a;
    logic       valid_a;
    logic       ready_a, serial_a, busy_a, done_a;
    logic [3:0] data_b;
    logic       valid_b;
    logic       ready_b, serial_b, busy_b, done_b;

    int checks = 0;
    int errors = 0;

    bit exp_a[$];
    bit exp_b[$];
    bit mon_exp;

    serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) dut_a (
        .clock     (clk),
        .reset     (reset),
        .data_in   (data_a),
        .load_valid(valid_a),
        .load_ready(ready_a),
        .serial_out(serial_a),
        .busy      (busy_a),
        .done      (done_a)
    );

    serial_frame_tx #(.WIDTH(4), .CLKS_PER_BIT(1)) dut_b (
        .clock     (clk),
        .reset     (reset),
        .data_in   (data_b),
        .load_valid(valid_b),
        .load_ready(ready_b),
        .serial_out(serial_b),
        .busy      (busy_b),
        .done      (done_b)
    );

    // Reference line model for the default instance: start, 8 data bits LSB first, stop; 4 cycles each.
    function automatic void push_a(input logic [7:0] d);
        for (int i = 0; i < 4; i++) exp_a.push_back(1'b0);
        for (int b = 0; b < 8; b++)
            for (int i = 0; i < 4; i++) exp_a.push_back(d[b]);
        for (int i = 0; i < 4; i++) exp_a.push_back(1'b1);
    endfunction

    // Scoreboard for the default instance: every busy cycle consumes one expected line value.
    always @(negedge clk) begin
        if (busy_a === 1'b1) begin
            checks++;
            if (exp_a.size() == 0) begin
                errors++;
                $display("FAIL frame_bit_a: busy with serial_out=%b but no bit expected", serial_a);
            end else begin
                mon_exp = exp_a.pop_front();
                if (serial_a !== mon_exp) begin
                    errors++;
                    $display("FAIL frame_bit_a: serial_out=%b expected %b (%0d bits left)",
                             serial_a, mon_exp, exp_a.size());
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({serial_a, busy_a, done_a, ready_a} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_state_a: {serial,busy,done,ready}=%b expected 1000",
                     {serial_a, busy_a, done_a, ready_a});
        end
        checks++;
        if (dut_a.state !== IDLE) begin
            errors++;
            $display("FAIL reset_fsm_a: state=%0d expected %0d", dut_a.state, IDLE);
        end
        checks++;
        if ({serial_b, busy_b, done_b, ready_b} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_state_b: {serial,busy,done,ready}=%b expected 1000",
                     {serial_b, busy_b, done_b, ready_b});
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (ready_a !== 1'b1 || ready_b !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: ready_a=%b ready_b=%b expected 1 1", ready_a, ready_b);
        end
    endtask

    task automatic test_idle();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if ({serial_a, ready_a, busy_a, done_a} !== 4'b1100) begin
                errors++;
                $display("FAIL idle_outputs: cycle %0d {serial,ready,busy,done}=%b expected 1100",
                         c, {serial_a, ready_a, busy_a, done_a});
            end
        end
    endtask

    task automatic test_single_frame();
        data_a  = 8'hA5;
        valid_a = 1'b1;
        push_a(8'hA5);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            valid_a = 1'b0;
            checks++;
            if ({busy_a, done_a} !== 2'b10) begin
                errors++;
                $display("FAIL single_busy: cycle %0d {busy,done}=%b expected 10", c, {busy_a, done_a});
            end
        end
        @(negedge clk);
        checks++;
        if ({busy_a, done_a, ready_a, serial_a} !== 4'b0111) begin
            errors++;
            $display("FAIL single_done: {busy,done,ready,serial}=%b expected 0111",
                     {busy_a, done_a, ready_a, serial_a});
        end
        checks++;
        if (exp_a.size() != 0) begin
            errors++;
            $display("FAIL single_length: %0d bits not sent, expected 0", exp_a.size());
        end
        @(negedge clk);
        checks++;
        if (done_a !== 1'b0) begin
            errors++;
            $display("FAIL single_done_width: done=%b expected 0", done_a);
        end
    endtask

    task automatic test_back_to_back();
        data_a  = 8'h00;
        valid_a = 1'b1;
        push_a(8'h00);
        push_a(8'hFF);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            data_a = 8'hFF;
            checks++;
            if (busy_a !== 1'b1) begin
                errors++;
                $display("FAIL b2b_busy1: cycle %0d busy=%b expected 1", c, busy_a);
            end
        end
        @(negedge clk);
        checks++;
        if ({busy_a, done_a, serial_a} !== 3'b011) begin
            errors++;
            $display("FAIL b2b_gap: {busy,done,serial}=%b expected 011", {busy_a, done_a, serial_a});
        end
        checks++;
        if (exp_a.size() != 40) begin
            errors++;
            $display("FAIL b2b_first_length: %0d bits queued, expected 40", exp_a.size());
        end
        @(negedge clk);
        valid_a = 1'b0;
        checks++;
        if ({busy_a, serial_a} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_restart: {busy,serial}=%b expected 10", {busy_a, serial_a});
        end
        for (int c = 2; c <= 40; c++) begin
            @(negedge clk);
            checks++;
            if (busy_a !== 1'b1) begin
                errors++;
                $display("FAIL b2b_busy2: cycle %0d busy=%b expected 1", c, busy_a);
            end
        end
        @(negedge clk);
        checks++;
        if (done_a !== 1'b1 || exp_a.size() != 0) begin
            errors++;
            $display("FAIL b2b_second_end: done=%b left=%0d expected 1 0", done_a, exp_a.size());
        end
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_third: busy=%b expected 0", busy_a);
        end
    endtask

    task automatic test_ignore_midframe();
        data_a  = 8'h5A;
        valid_a = 1'b1;
        push_a(8'h5A);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            data_a  = ~data_a;
            valid_a = (c <= 38) && (c % 3 == 0);
            checks++;
            if (busy_a !== 1'b1) begin
                errors++;
                $display("FAIL ignore_busy: cycle %0d busy=%b expected 1", c, busy_a);
            end
        end
        @(negedge clk);
        checks++;
        if (done_a !== 1'b1 || exp_a.size() != 0) begin
            errors++;
            $display("FAIL ignore_end: done=%b left=%0d expected 1 0", done_a, exp_a.size());
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (busy_a !== 1'b0) begin
                errors++;
                $display("FAIL ignore_no_second: cycle %0d busy=%b expected 0", c, busy_a);
            end
        end
    endtask

    task automatic test_reset_abort();
        data_a  = 8'hC3;
        valid_a = 1'b1;
        push_a(8'hC3);
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            valid_a = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({serial_a, busy_a, done_a, ready_a} !== 4'b1000) begin
            errors++;
            $display("FAIL abort_outputs: {serial,busy,done,ready}=%b expected 1000",
                     {serial_a, busy_a, done_a, ready_a});
        end
        checks++;
        if (dut_a.state !== IDLE) begin
            errors++;
            $display("FAIL abort_fsm: state=%0d expected %0d", dut_a.state, IDLE);
        end
        checks++;
        if (exp_a.size() != 27) begin
            errors++;
            $display("FAIL abort_bits_sent: %0d bits left, expected 27", exp_a.size());
        end
        exp_a.delete();
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if ({busy_a, done_a} !== 2'b00) begin
                errors++;
                $display("FAIL abort_no_done: cycle %0d {busy,done}=%b expected 00", c, {busy_a, done_a});
            end
        end
        data_a  = 8'h3C;
        valid_a = 1'b1;
        push_a(8'h3C);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            valid_a = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (done_a !== 1'b1 || exp_a.size() != 0) begin
            errors++;
            $display("FAIL abort_next_frame: done=%b left=%0d expected 1 0", done_a, exp_a.size());
        end
    endtask

    task automatic test_fast();
        bit e;
        data_b  = 4'b1001;
        valid_b = 1'b1;
        exp_b.push_back(1'b0);
        for (int b = 0; b < 4; b++) exp_b.push_back(data_b[b]);
        exp_b.push_back(1'b1);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            valid_b = 1'b0;
            data_b  = 4'b0110;
            e = exp_b.pop_front();
            checks++;
            if (serial_b !== e || busy_b !== 1'b1) begin
                errors++;
                $display("FAIL fast_bit: cycle %0d serial=%b busy=%b expected %b 1", c, serial_b, busy_b, e);
            end
        end
        @(negedge clk);
        checks++;
        if ({done_b, busy_b, serial_b} !== 3'b101) begin
            errors++;
            $display("FAIL fast_done: {done,busy,serial}=%b expected 101", {done_b, busy_b, serial_b});
        end
        @(negedge clk);
        checks++;
        if (done_b !== 1'b0) begin
            errors++;
            $display("FAIL fast_done_width: done=%b expected 0", done_b);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        data_a  = 8'h00;
        valid_a = 1'b0;
        data_b  = 4'h0;
        valid_b = 1'b0;
        test_reset();
        test_idle();
        test_single_frame();
        test_back_to_back();
        test_ignore_midframe();
        test_reset_abort();
        test_fast();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
